switch_out_queue: RTL and testbench
===================================

# switch_out_queue

Per-port output queue of the switch: stores packet bytes arriving from the switch fabric and presents complete packets to one output port (`port`/`ready`/`read`). It is the stage directly upstream of the output-port interface; four instances drive `port0..3`, `ready_0..3` and receive `read_0..3`. Packets are committed atomically, so `ready` never advertises a partially received packet. Overflowing packets are discarded whole.

## Interface
- `DEPTH`, 64, byte entries of storage; power of 2, ≥4
- `clock`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `in_data`  input  8  packet byte from fabric
- `in_valid`  input  1  `in_data` valid this cycle
- `in_eop`  input  1  qualifies `in_data` as last byte of packet
- `in_full`  output  1  queue occupancy == `DEPTH`; fabric should stall
- `pkt_drop`  output  1  one-cycle pulse: a packet was discarded
- `port`  output  8  byte at queue head; 8'h00 while `ready` low
- `ready`  output  1  at least one complete packet stored
- `read`  input  1  receiver consumes head byte on this edge

## Operation
- Storage: `DEPTH` entries of {eop, byte}; pointers `wr_ptr`, `commit_ptr`, `rd_ptr`, each log2(DEPTH)+1 bits (wrap bit). Occupancy = `wr_ptr - rd_ptr` (mod 2·DEPTH), includes uncommitted bytes.
- Packet counter `pkt_cnt`, log2(DEPTH)+1 bits: number of committed, not-fully-read packets.
- Write, `in_valid`=1, packet not flagged bad, occupancy < DEPTH: store {in_eop, in_data} at `wr_ptr`, `wr_ptr`+1.
  - If `in_eop`: `commit_ptr` <= `wr_ptr`+1, `pkt_cnt`+1.
- Overflow: `in_valid`=1 with occupancy == DEPTH (sampled before this edge's pop) → byte discarded, internal `bad` flag set. While `bad`, further bytes are discarded.
- Bad packet end: `in_valid`&`in_eop` with `bad` set (or with overflow this cycle) → `wr_ptr` <= `commit_ptr`, `bad` cleared, `pkt_drop`=1 next cycle for one cycle; `pkt_cnt` unchanged.
- Packets longer than `DEPTH` are always dropped. A single-byte packet (`in_eop` on first byte) is valid.
- Read: `read`=1 and `ready`=1 → `rd_ptr`+1. If the popped entry has eop set, `pkt_cnt`-1. `read` while `ready`=0 is ignored.
- Commit and eop-pop on the same edge: `pkt_cnt` unchanged.
- `ready` = (`pkt_cnt` != 0). `port` = stored byte at `rd_ptr` when `ready`, else 8'h00.
- Receiver determines packet boundaries from the packet length field; `ready` stays high across back-to-back committed packets.

## Timing
- Reset: all pointers 0, `pkt_cnt`=0, `bad`=0, `ready`=0, `port`=8'h00, `in_full`=0, `pkt_drop`=0. Reset mid-packet discards all stored and partial data; no `pkt_drop` is generated.
- Write-to-ready latency: `ready` rises the cycle after the edge that writes the eop byte.
- Read: `port` shows the next byte the cycle after a consuming edge. After the last committed eop byte is popped, `ready` and `port` (→8'h00) fall in the next cycle.
- `in_full` is a registered-state decode, valid the cycle after the edge that changes occupancy. A same-edge pop does not rescue a write seen against full.
- `pkt_drop` asserts the cycle after the eop of the discarded packet.
- Throughput: one write and one read per cycle, simultaneously.

## Test plan
- DEPTH=16. Write a 5-byte packet 8'h01..8'h05 (eop on 8'h05) → `ready`=0 until the cycle after the eop write, then `port`=8'h01. Hold `read`=1 for 5 cycles → `port` 01,02,03,04,05, then `ready`=0, `port`=8'h00.
- Two back-to-back packets (3 and 4 bytes) → `ready` stays high across the boundary. Reading 7 bytes returns them in order; `ready` falls only after the 7th byte.
- 20-byte packet into an empty queue → `in_full`=1 after 16 writes; the 17th byte sets `bad`. At the eop, `pkt_drop` pulses once, occupancy returns to 0, `ready` never asserts, `in_full` deasserts.
- Commit a 10-byte packet, then send a 10-byte packet → the second packet overflows and is dropped. The first packet still reads out intact with 10 bytes, and `pkt_cnt` returns to 0.
- Same-edge commit of packet B and pop of packet A's eop with `pkt_cnt`=1 → `ready` stays 1 and `port` shows B's first byte. Wrap-around: 5 × 7-byte packets written and read through DEPTH=16 are all returned intact.
- Assert `reset` one cycle in the middle of reading a packet → next cycle all outputs are at reset values. A new 2-byte packet 8'hAA,8'hBB then reads back correctly.

Source files
------------

// File: rtl/switch_out_queue_if.sv
// -----------------------------------------------------------------------------
// switch_out_queue_if
// Bundles the fabric-side write stream and the output-port read side of one
// per-port output queue.
//   in_data  [7:0] packet byte from fabric
//   in_valid       in_data valid this cycle
//   in_eop         in_data is the last byte of its packet
//   in_full        queue occupancy == DEPTH, fabric should stall
//   pkt_drop       one-cycle pulse: a packet was discarded
//   port     [7:0] byte at queue head, 8'h00 while ready is low
//   ready          at least one complete packet stored
//   read           receiver consumes the head byte on this edge
// The queue itself connects through the slave modport; the fabric/port
// environment connects through the master modport.
// -----------------------------------------------------------------------------
interface switch_out_queue_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_eop;
    logic       in_full;
    logic       pkt_drop;
    logic [7:0] port;
    logic       ready;
    logic       read;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_eop,
        input  read,
        output in_full,
        output pkt_drop,
        output port,
        output ready
    );

    modport master (
        output in_data,
        output in_valid,
        output in_eop,
        output read,
        input  in_full,
        input  pkt_drop,
        input  port,
        input  ready
    );
endinterface

// File: rtl/switch_out_queue.sv
// -----------------------------------------------------------------------------
// switch_out_queue
// Per-port output queue. Stores packet bytes from the switch fabric and
// presents only fully received packets to the output port. A packet is made
// visible atomically when its eop byte is written; a packet that runs into a
// full queue is discarded whole and reported with a one-cycle pkt_drop pulse.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    switch_out_queue_if.slave (fabric write side + output read side)
// Parameter:
//   DEPTH  byte entries of storage, power of 2, >= 4
// -----------------------------------------------------------------------------
module switch_out_queue #(
    parameter int DEPTH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    switch_out_queue_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Each entry holds {eop, byte}.
    logic [8:0]    r_mem [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_pkt_cnt;
    logic          r_bad;
    logic          r_pkt_drop;

    logic [PW-1:0] w_occ;
    logic          w_full;
    logic          w_ready;
    logic [8:0]    w_head;
    logic          w_pop;
    logic          w_pop_eop;
    logic          w_write;
    logic          w_commit;
    logic          w_overflow;
    logic          w_bad_end;

    // Occupancy counts uncommitted bytes too, so a partial packet can fill
    // the queue and be dropped.
    assign w_occ   = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_occ == PW'(DEPTH));
    assign w_ready = (r_pkt_cnt != '0);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop     = bus.read & w_ready;
    assign w_pop_eop = w_pop & w_head[8];

    // Fullness is judged on the state before this edge; a pop on the same
    // edge does not make room for the incoming byte.
    assign w_write    = bus.in_valid & ~r_bad & ~w_full;
    assign w_commit   = w_write & bus.in_eop;
    assign w_overflow = bus.in_valid & ~r_bad & w_full;
    assign w_bad_end  = bus.in_valid & bus.in_eop & (r_bad | w_full);

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.in_eop, bus.in_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_cnt    <= '0;
            r_bad        <= 1'b0;
            r_pkt_drop   <= 1'b0;
        end else begin
            r_pkt_drop <= w_bad_end;

            if (w_bad_end) begin
                // Rewind to the end of the last good packet, discarding the
                // partial one. Reads never pass commit_ptr, so this is safe
                // alongside a pop.
                r_wr_ptr <= r_commit_ptr;
                r_bad    <= 1'b0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (bus.in_eop) begin
                    r_commit_ptr <= r_wr_ptr + PW'(1);
                end
            end else if (w_overflow) begin
                r_bad <= 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            // A commit and an eop pop on the same edge cancel out.
            case ({w_commit, w_pop_eop})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
                2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    assign bus.in_full  = w_full;
    assign bus.pkt_drop = r_pkt_drop;
    assign bus.ready    = w_ready;
    assign bus.port     = w_ready ? w_head[7:0] : 8'h00;

endmodule

// File: tb/tb_switch_out_queue.sv
module tb_switch_out_queue;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0] sb[$];
    logic [7:0] exp_b;

    switch_out_queue_if bus ();

    switch_out_queue #(.DEPTH(16)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read n bytes with read held high, comparing each head byte to the
    // scoreboard before the consuming edge.
    task automatic test_read_out(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            exp_b = sb.pop_front();
            bus.read = 1'b1;
            checks++;
            if (bus.ready !== 1'b1 || bus.port !== exp_b) begin
                failures++;
                $display("FAIL %s byte%0d: ready=%b port=%02h, required ready=1 port=%02h",
                         name, k, bus.ready, bus.port, exp_b);
            end else
                $display("%s: read byte%0d port=%02h", name, k, bus.port);
            tick();
        end
        bus.read = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00 || bus.in_full !== 1'b0 || bus.pkt_drop !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b port=%02h in_full=%b pkt_drop=%b, required 0/00/0/0",
                     bus.ready, bus.port, bus.in_full, bus.pkt_drop);
        end else
            $display("reset: outputs at reset values");
    endtask

    task automatic test_single_packet();
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            bus.in_eop   = (i == 5);
            sb.push_back(8'(i));
            checks++;
            if (bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL single_early_ready: ready=%b before byte %0d, required 0", bus.ready, i);
            end else
                $display("single: write byte %02h", i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.port !== 8'h01) begin
            failures++;
            $display("FAIL single_ready: ready=%b port=%02h, required 1/01", bus.ready, bus.port);
        end
        test_read_out("single", 5);
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00) begin
            failures++;
            $display("FAIL single_empty: ready=%b port=%02h, required 0/00", bus.ready, bus.port);
        end else
            $display("single: queue empty after read");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i < 3) ? 8'(8'h10 + i) : 8'(8'h20 + i);
            bus.in_eop   = (i == 2) || (i == 6);
            sb.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        test_read_out("b2b", 7);
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00) begin
            failures++;
            $display("FAIL b2b_empty: ready=%b port=%02h, required 0/00", bus.ready, bus.port);
        end else
            $display("b2b: queue empty after 7 bytes");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            if (i == 16) begin
                checks++;
                if (bus.in_full !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_full: in_full=%b after 16 writes, required 1", bus.in_full);
                end else
                    $display("ovf: in_full after 16 writes");
            end
            checks++;
            if (bus.ready !== 1'b0 || bus.pkt_drop !== 1'b0) begin
                failures++;
                $display("FAIL ovf_during: ready=%b pkt_drop=%b at byte %0d, required 0/0",
                         bus.ready, bus.pkt_drop, i);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h40 + i);
            bus.in_eop   = (i == 19);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        checks++;
        if (bus.pkt_drop !== 1'b1 || bus.in_full !== 1'b0 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drop: pkt_drop=%b in_full=%b ready=%b, required 1/0/0",
                     bus.pkt_drop, bus.in_full, bus.ready);
        end else
            $display("ovf: packet dropped");
        tick();
        checks++;
        if (bus.pkt_drop !== 1'b0 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pulse: pkt_drop=%b ready=%b, required 0/0", bus.pkt_drop, bus.ready);
        end
    endtask

    task automatic test_commit_then_overflow();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i < 10) ? 8'(8'h50 + i) : 8'(8'h60 + i);
            bus.in_eop   = (i == 9) || (i == 19);
            if (i < 10) sb.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        checks++;
        if (bus.pkt_drop !== 1'b1) begin
            failures++;
            $display("FAIL cov_drop: pkt_drop=%b, required 1", bus.pkt_drop);
        end else
            $display("cov: second packet dropped");
        tick();
        test_read_out("cov", 10);
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00) begin
            failures++;
            $display("FAIL cov_empty: ready=%b port=%02h, required 0/00", bus.ready, bus.port);
        end
    endtask

    task automatic test_same_edge();
        // Packet A (2 bytes) committed first.
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h70 + i);
            bus.in_eop   = (i == 1);
            sb.push_back(bus.in_data);
            tick();
        end
        for (int i = 0; i < 3; i++) sb.push_back(8'(8'h80 + i));
        // Write B while reading A; B's eop commit coincides with A's eop pop.
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h80 + c);
            bus.in_eop   = (c == 2);
            bus.read     = (c >= 1);
            if (c >= 1) begin
                exp_b = sb.pop_front();
                checks++;
                if (bus.ready !== 1'b1 || bus.port !== exp_b) begin
                    failures++;
                    $display("FAIL same_edge_A%0d: ready=%b port=%02h, required 1/%02h",
                             c - 1, bus.ready, bus.port, exp_b);
                end else
                    $display("same_edge: read A byte %02h while writing %02h", bus.port, bus.in_data);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        bus.read     = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.port !== 8'h80) begin
            failures++;
            $display("FAIL same_edge_B: ready=%b port=%02h, required 1/80", bus.ready, bus.port);
        end
        test_read_out("same_edge", 3);
        checks++;
        if (bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL same_edge_empty: ready=%b, required 0", bus.ready);
        end
    endtask

    task automatic test_wrap();
        for (int p = 0; p <= 5; p++) begin
            for (int b = 0; b < 7; b++) begin
                bus.in_valid = (p < 5);
                bus.in_data  = {4'(p + 1), 4'(b)};
                bus.in_eop   = (p < 5) && (b == 6);
                if (p < 5) sb.push_back(bus.in_data);
                bus.read = (p > 0);
                if (p > 0) begin
                    exp_b = sb.pop_front();
                    checks++;
                    if (bus.ready !== 1'b1 || bus.port !== exp_b) begin
                        failures++;
                        $display("FAIL wrap_p%0d_b%0d: ready=%b port=%02h, required 1/%02h",
                                 p - 1, b, bus.ready, bus.port, exp_b);
                    end else
                        $display("wrap: pkt%0d byte%0d port=%02h", p - 1, b, bus.port);
                end
                tick();
            end
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        bus.read     = 1'b0;
        checks++;
        if (bus.ready !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_empty: ready=%b sb=%0d, required 0/0", bus.ready, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h90 + i);
            bus.in_eop   = (i == 3);
            sb.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        test_read_out("mid_reset", 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00 || bus.in_full !== 1'b0 || bus.pkt_drop !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_state: ready=%b port=%02h in_full=%b pkt_drop=%b, required 0/00/0/0",
                     bus.ready, bus.port, bus.in_full, bus.pkt_drop);
        end else
            $display("mid_reset: outputs at reset values");
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 0) ? 8'hAA : 8'hBB;
            bus.in_eop   = (i == 1);
            sb.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        test_read_out("post_reset", 2);
        checks++;
        if (bus.ready !== 1'b0 || bus.port !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_empty: ready=%b port=%02h, required 0/00", bus.ready, bus.port);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_eop   = 1'b0;
        bus.read     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_overflow();
        test_commit_then_overflow();
        test_same_edge();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
